// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the CPU datapath.
// master: the sequencer (reads ir/mem_ready/stop, drives run, alu_op and all strobes)
// slave : the datapath/memory side (mirror directions)
interface control_sequencer_if;
    localparam int unsigned OPC_W = 5;

    // datapath / memory feedback
    logic [31:0]      ir;
    logic             mem_ready;
    logic             stop;

    // status and ALU opcode
    logic             run;
    logic [OPC_W-1:0] alu_op;

    // datapath strobes
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout;

    // register select / encode controls
    logic Gra, Grb, Grc, Rin, Rout, BAout;

    // memory request strobes
    logic Read, Write;

    modport master (
        input  ir, mem_ready, stop,
        output run, alu_op,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, Write
    );

    modport slave (
        output ir, mem_ready, stop,
        input  run, alu_op,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, Write
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch (T0-T2) and execute (T3-T7) phases and
// decodes the opcode in ir[31:27] into datapath strobes.
// Ports:
//   clock : system clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : control_sequencer_if.master (ir, mem_ready, stop in; run, alu_op,
//           datapath strobes, register controls, Read/Write out)
// Strobes are decoded from the state register so that clear removes them in the
// same time step; MDRin in the two memory-read wait states follows mem_ready.
module control_sequencer #(
    parameter logic [4:0] OPC_ADD  = 5'b00011,
    parameter logic [4:0] OPC_LD   = 5'b00000,
    parameter logic [4:0] OPC_ST   = 5'b00010,
    parameter logic [4:0] OPC_MUL  = 5'b01111,
    parameter logic [4:0] OPC_DIV  = 5'b10000,
    parameter logic [4:0] OPC_NOP  = 5'b11010,
    parameter logic [4:0] OPC_HALT = 5'b11011
) (
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);
    localparam int unsigned OPC_W = 5;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_MULDIV, C_LD, C_ST, C_NOP, C_HALT
    } op_class_t;

    state_t           state;
    state_t           state_nx;
    logic             t1_wait;     // set once T1 has already spent a cycle waiting
    logic [OPC_W-1:0] op_q;        // opcode captured at decode
    logic [OPC_W-1:0] opcode;
    logic [OPC_W-1:0] cur_op;
    op_class_t        op_class;

    // Only the opcode field is decoded here; the rest of IR belongs to the datapath.
    logic unused_ir;
    assign unused_ir = ^bus.ir[26:0];

    assign opcode = bus.ir[31:27];
    // Decode uses IR live in T3, then the captured copy for the rest of the instruction.
    assign cur_op = (state == S_T3) ? opcode : op_q;

    // Instruction class
    always_comb begin
        op_class = C_ALU;
        if (cur_op == OPC_LD)                              op_class = C_LD;
        else if (cur_op == OPC_ST)                         op_class = C_ST;
        else if ((cur_op == OPC_MUL) || (cur_op == OPC_DIV)) op_class = C_MULDIV;
        else if (cur_op == OPC_NOP)                        op_class = C_NOP;
        else if (cur_op == OPC_HALT)                       op_class = C_HALT;
    end

    // State register, T1 wait flag and opcode capture
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_RESET;
            t1_wait <= 1'b0;
            op_q    <= '0;
        end else begin
            state   <= state_nx;
            t1_wait <= (state == S_T1) && (state_nx == S_T1);
            if (state == S_T3) begin
                op_q <= opcode;
            end
        end
    end

    // Next state and strobe decode
    always_comb begin
        state_nx     = state;
        bus.run      = (state != S_RESET) && (state != S_HALTED);
        bus.alu_op   = '0;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Cout     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Read     = 1'b0;
        bus.Write    = 1'b0;

        case (state)
            S_RESET: state_nx = S_T0;

            // PC -> MAR, PC+1 -> Z; stop is honoured only here
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_nx  = bus.stop ? S_HALTED : S_T1;
            end

            // Z -> PC on the first cycle only, read held until memory responds
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = !t1_wait;
                bus.Read    = 1'b1;
                bus.MDRin   = bus.mem_ready;
                state_nx    = bus.mem_ready ? S_T2 : S_T1;
            end

            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nx   = S_T3;
            end

            S_T3: begin
                state_nx = S_T4;
                case (op_class)
                    C_MULDIV: begin
                        bus.Gra  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    C_LD, C_ST: begin
                        bus.Grb   = 1'b1;
                        bus.BAout = 1'b1;
                        bus.Yin   = 1'b1;
                    end
                    C_NOP:   state_nx = S_T0;
                    C_HALT:  state_nx = S_HALTED;
                    default: begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                endcase
            end

            S_T4: begin
                state_nx = S_T5;
                case (op_class)
                    C_MULDIV: begin
                        bus.Grb    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = cur_op;
                    end
                    // base + offset address computation
                    C_LD, C_ST: begin
                        bus.Cout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = OPC_ADD;
                    end
                    C_NOP, C_HALT: state_nx = S_T0;
                    default: begin
                        bus.Grc    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Zin    = 1'b1;
                        bus.alu_op = cur_op;
                    end
                endcase
            end

            S_T5: begin
                case (op_class)
                    C_MULDIV: begin
                        bus.Zlowout = 1'b1;
                        bus.LOin    = 1'b1;
                        state_nx    = S_T6;
                    end
                    C_LD, C_ST: begin
                        bus.Zlowout = 1'b1;
                        bus.MARin   = 1'b1;
                        state_nx    = S_T6;
                    end
                    C_NOP, C_HALT: state_nx = S_T0;
                    default: begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                        state_nx    = S_T0;
                    end
                endcase
            end

            S_T6: begin
                state_nx = S_T0;
                case (op_class)
                    C_MULDIV: begin
                        bus.Zhighout = 1'b1;
                        bus.HIin     = 1'b1;
                    end
                    C_LD: begin
                        bus.Read  = 1'b1;
                        bus.MDRin = bus.mem_ready;
                        state_nx  = bus.mem_ready ? S_T7 : S_T6;
                    end
                    // store data Ra -> MDR
                    C_ST: begin
                        bus.Gra   = 1'b1;
                        bus.Rout  = 1'b1;
                        bus.MDRin = 1'b1;
                        state_nx  = S_T7;
                    end
                    default: state_nx = S_T0;
                endcase
            end

            S_T7: begin
                state_nx = S_T0;
                case (op_class)
                    C_LD: begin
                        bus.MDRout = 1'b1;
                        bus.Gra    = 1'b1;
                        bus.Rin    = 1'b1;
                    end
                    C_ST: begin
                        bus.Write = 1'b1;
                        state_nx  = bus.mem_ready ? S_T0 : S_T7;
                    end
                    default: state_nx = S_T0;
                endcase
            end

            S_HALTED: state_nx = S_HALTED;

            default: state_nx = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each instruction is expanded by a
// per-opcode step table into per-cycle stimulus plus the exact output vector
// expected in that cycle; one compare process checks every cycle.
module tb_control_sequencer;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [31:0] IR_ADD  = 32'h18908000; // 00011 ra=1 rb=2 rc=1
    localparam logic [31:0] IR_SUB  = 32'h28908000; // 00101, generic ALU op
    localparam logic [31:0] IR_MUL  = 32'h78908000; // 01111
    localparam logic [31:0] IR_DIV  = 32'h80908000; // 10000
    localparam logic [31:0] IR_LD   = 32'h00800000; // 00000
    localparam logic [31:0] IR_ST   = 32'h10800000; // 00010
    localparam logic [31:0] IR_NOP  = 32'hD0000000; // 11010
    localparam logic [31:0] IR_HALT = 32'hD8000000; // 11011

    // strobe bit positions in the expected/observed vector
    localparam logic [21:0] M_PCOUT   = 22'h000001 << 0;
    localparam logic [21:0] M_PCIN    = 22'h000001 << 1;
    localparam logic [21:0] M_INCPC   = 22'h000001 << 2;
    localparam logic [21:0] M_MARIN   = 22'h000001 << 3;
    localparam logic [21:0] M_MDRIN   = 22'h000001 << 4;
    localparam logic [21:0] M_MDROUT  = 22'h000001 << 5;
    localparam logic [21:0] M_IRIN    = 22'h000001 << 6;
    localparam logic [21:0] M_YIN     = 22'h000001 << 7;
    localparam logic [21:0] M_ZIN     = 22'h000001 << 8;
    localparam logic [21:0] M_ZHIGH   = 22'h000001 << 9;
    localparam logic [21:0] M_ZLOW    = 22'h000001 << 10;
    localparam logic [21:0] M_HIIN    = 22'h000001 << 11;
    localparam logic [21:0] M_LOIN    = 22'h000001 << 12;
    localparam logic [21:0] M_COUT    = 22'h000001 << 13;
    localparam logic [21:0] M_GRA     = 22'h000001 << 14;
    localparam logic [21:0] M_GRB     = 22'h000001 << 15;
    localparam logic [21:0] M_GRC     = 22'h000001 << 16;
    localparam logic [21:0] M_RIN     = 22'h000001 << 17;
    localparam logic [21:0] M_ROUT    = 22'h000001 << 18;
    localparam logic [21:0] M_BAOUT   = 22'h000001 << 19;
    localparam logic [21:0] M_READ    = 22'h000001 << 20;
    localparam logic [21:0] M_WRITE   = 22'h000001 << 21;
    localparam logic [21:0] M_NONE    = 22'h000000;

    typedef struct {
        logic        clr;
        logic        mr;
        logic        stp;
        logic [31:0] ir;
        logic [27:0] exp;   // {run, alu_op, strobes}
        int          tag;   // selects an extra literal check
        string       name;
    } step_t;

    logic clock;
    logic clear;
    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    step_t steps[$];
    int    cur;
    logic  drive_valid;
    logic  bg_stop;
    int    n_tests;
    int    n_fail;

    task automatic push(input logic clr, input logic mr, input logic stp,
                        input logic [31:0] ir_v, input logic run_v,
                        input logic [4:0] op, input logic [21:0] s,
                        input int tag, input string name);
        step_t t;
        t.clr  = clr;
        t.mr   = mr;
        t.stp  = stp;
        t.ir   = ir_v;
        t.exp  = {run_v, op, s};
        t.tag  = tag;
        t.name = name;
        steps.push_back(t);
    endtask

    // n cycles with clear low, then one cycle still in RESET after release
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, M_NONE, 7, "reset");
        push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, M_NONE, 0, "reset_rel");
    endtask

    task automatic do_halted(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, bg_stop, 32'h0, 1'b0, 5'd0, M_NONE, 5, "halted");
    endtask

    task automatic do_fetch(input logic [31:0] ir_v, input int waits, input logic halt_req);
        logic rdy;
        push(1'b1, 1'b1, halt_req, ir_v, 1'b1, 5'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1, "T0");
        if (!halt_req) begin
            for (int w = 0; w <= waits; w++) begin
                rdy = (w == waits);
                push(1'b1, rdy, bg_stop, ir_v, 1'b1, 5'd0,
                     M_ZLOW | M_READ | ((w == 0) ? M_PCIN : M_NONE) | (rdy ? M_MDRIN : M_NONE),
                     0, "T1");
            end
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_MDROUT | M_IRIN, 0, "T2");
        end
    endtask

    // waits: mem_ready-low cycles in the memory phase; abort: pulse clear mid-wait (LD)
    task automatic do_exec(input logic [31:0] ir_v, input int waits, input bit abort);
        logic [4:0] op;
        logic       rdy;
        op = ir_v[31:27];
        if (op == OPC_NOP) begin
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_NONE, 0, "T3_nop");
        end else if (op == OPC_HALT) begin
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_NONE, 0, "T3_halt");
            do_halted(20);
        end else if ((op == OPC_MUL) || (op == OPC_DIV)) begin
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_GRA | M_ROUT | M_YIN, 0, "T3_md");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, op, M_GRB | M_ROUT | M_ZIN, 0, "T4_md");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_ZLOW | M_LOIN, 0, "T5_md");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_ZHIGH | M_HIIN, (op == OPC_MUL) ? 3 : 0, "T6_md");
        end else if ((op == OPC_LD) || (op == OPC_ST)) begin
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_GRB | M_BAOUT | M_YIN, 0, "T3_mem");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, OPC_ADD, M_COUT | M_ZIN, 6, "T4_mem");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_ZLOW | M_MARIN, 0, "T5_mem");
            if (op == OPC_LD) begin
                if (abort) begin
                    for (int w = 0; w < waits; w++)
                        push(1'b1, 1'b0, bg_stop, ir_v, 1'b1, 5'd0, M_READ, 0, "T6_ld_wait");
                    do_reset(1);
                end else begin
                    for (int w = 0; w <= waits; w++) begin
                        rdy = (w == waits);
                        push(1'b1, rdy, bg_stop, ir_v, 1'b1, 5'd0,
                             M_READ | (rdy ? M_MDRIN : M_NONE), 0, "T6_ld");
                    end
                    push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_MDROUT | M_GRA | M_RIN, 0, "T7_ld");
                end
            end else begin
                push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_GRA | M_ROUT | M_MDRIN, 4, "T6_st");
                for (int w = 0; w <= waits; w++) begin
                    rdy = (w == waits);
                    push(1'b1, rdy, bg_stop, ir_v, 1'b1, 5'd0, M_WRITE, 0, "T7_st");
                end
            end
        end else begin
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_GRB | M_ROUT | M_YIN, 0, "T3_alu");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, op, M_GRC | M_ROUT | M_ZIN, (op == OPC_ADD) ? 2 : 0, "T4_alu");
            push(1'b1, 1'b1, bg_stop, ir_v, 1'b1, 5'd0, M_ZLOW | M_GRA | M_RIN, 0, "T5_alu");
        end
    endtask

    task automatic lit(input logic ok, input string name, input logic [27:0] got);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lit_%s: got=%h does not meet hand-computed expectation", name, got);
        end
    endtask

    // Compare process: every driven cycle, away from the active edge
    initial begin
        logic [27:0] got;
        forever begin
            @(negedge clock);
            #2;
            if (drive_valid) begin
                got = {bus.run, bus.alu_op,
                       bus.Write, bus.Read, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                       bus.Cout, bus.LOin, bus.HIin, bus.Zlowout, bus.Zhighout, bus.Zin, bus.Yin,
                       bus.IRin, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout};
                n_tests++;
                if (got !== steps[cur].exp) begin
                    n_fail++;
                    $display("FAIL step%0d %s: got=%h want=%h", cur, steps[cur].name, got, steps[cur].exp);
                end
                case (steps[cur].tag)
                    1: lit({bus.run, bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.IRin} === 6'b111110, "T0", got);
                    2: lit((bus.alu_op === 5'b00011) && ({bus.Grc, bus.Rout, bus.Zin} === 3'b111), "alu_T4", got);
                    3: lit({bus.HIin, bus.Zhighout, bus.LOin} === 3'b110, "mul_T6", got);
                    4: lit({bus.MDRin, bus.Read, bus.Write} === 3'b100, "st_T6", got);
                    5: lit({bus.run, bus.alu_op, bus.Read, bus.Write} === 8'b0, "halted", got);
                    6: lit((bus.alu_op === 5'b00011) && (bus.Cout === 1'b1), "mem_T4", got);
                    7: lit({bus.run, bus.Read, bus.Write, bus.MDRin} === 4'b0, "clear", got);
                    default: ;
                endcase
            end
        end
    end

    // Stimulus program and driver
    initial begin
        clear         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.stop      = 1'b0;
        bus.ir        = 32'h0;
        drive_valid   = 1'b0;
        cur           = 0;
        n_tests       = 0;
        n_fail        = 0;
        bg_stop       = 1'b0;

        do_reset(3);
        do_fetch(IR_NOP, 0, 1'b0);  do_exec(IR_NOP, 0, 1'b0);
        do_fetch(IR_ADD, 4, 1'b0);  do_exec(IR_ADD, 0, 1'b0);
        do_fetch(IR_MUL, 0, 1'b0);  do_exec(IR_MUL, 0, 1'b0);
        do_fetch(IR_DIV, 1, 1'b0);  do_exec(IR_DIV, 0, 1'b0);
        bg_stop = 1'b1;             // stop outside T0 must be ignored
        do_fetch(IR_SUB, 0, 1'b0);  do_exec(IR_SUB, 0, 1'b0);
        bg_stop = 1'b0;
        do_fetch(IR_LD, 0, 1'b0);   do_exec(IR_LD, 2, 1'b0);
        do_fetch(IR_ST, 0, 1'b0);   do_exec(IR_ST, 3, 1'b0);
        do_fetch(IR_ST, 0, 1'b0);   do_exec(IR_ST, 0, 1'b0);
        do_fetch(IR_HALT, 0, 1'b0); do_exec(IR_HALT, 0, 1'b0);
        do_reset(2);
        do_fetch(IR_NOP, 0, 1'b1);  do_halted(5);
        do_reset(1);
        do_fetch(IR_LD, 0, 1'b0);   do_exec(IR_LD, 2, 1'b1);
        do_fetch(IR_NOP, 0, 1'b0);  do_exec(IR_NOP, 0, 1'b0);
        do_fetch(IR_ADD, 0, 1'b0);  do_exec(IR_ADD, 0, 1'b0);

        foreach (steps[i]) begin
            @(negedge clock);
            clear         = steps[i].clr;
            bus.mem_ready = steps[i].mr;
            bus.stop      = steps[i].stp;
            bus.ir        = steps[i].ir;
            cur           = i;
            drive_valid   = 1'b1;
        end
        @(negedge clock);
        drive_valid = 1'b0;
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
